uart_fifo_core: RTL

//  Parametrised full-duplex UART with TX and RX FIFOs, optional parity, 1/2 stop bits and sticky error flags.

---
 rtl/uart_fifo_core_pkg.sv | 32 +++
 rtl/uart_fifo_core_sync_fifo.sv | 51 +++++
 rtl/uart_fifo_core.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_core_pkg.sv
// Shared definitions for the buffered UART.
//   - parity mode encodings
//   - TX and RX state encodings
//   - par_calc: turns the XOR-reduction of a word into the parity bit for a mode
package uart_fifo_core_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT
   } rx_state_t;

   function automatic logic par_calc(input logic xor_red, input int mode);
      return (mode == PAR_ODD) ? ~xor_red : xor_red;
   endfunction

endpackage

// File: rtl/uart_fifo_core_sync_fifo.sv
// Synchronous FIFO with first-word fall-through head.
//   clk, rst_n       clock, async active-low reset (pointers only)
//   push_en/push_data write side; a push into a full FIFO is taken only
//                    when a pop happens in the same cycle
//   pop_en           pop head; ignored when empty
//   head             current head word, forced to 0 while empty
//   full, empty      status
module uart_fifo_core_sync_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_en,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop_en,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              push_ok;
   logic              pop_ok;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_ok  = pop_en && !empty;
   assign push_ok = push_en && (!full || pop_ok);
   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/uart_fifo_core.sv
// Full-duplex UART with TX/RX FIFOs, optional parity, 1 or 2 stop bits and
// sticky error flags.
//   clk, rst_n          clock, async active-low reset
//   wr_en, din, wr_rdy  host push into TX FIFO
//   rd_en, dout, rd_rdy host pop from RX FIFO (dout is the fall-through head)
//   tx_busy             transmitter active or TX FIFO non-empty
//   err_clr             clears par_err / frm_err / ovr_err (a new error wins)
//   rx, tx              serial pins, idle high
//
// TX states
//   TX_IDLE   | line idle, waiting for TX FIFO data
//   TX_START  | start bit
//   TX_DATA   | data bits, LSB first
//   TX_PARITY | parity bit (only when PARITY != 0)
//   TX_STOP   | stop bit(s)
// RX states
//   RX_IDLE   | waiting for falling edge on synchronised rx
//   RX_START  | half-bit wait, then confirm start bit still low
//   RX_DATA   | sample data bits at mid-bit
//   RX_PARITY | sample and check parity bit
//   RX_STOP   | sample first stop bit, push word
//   RX_WAIT   | wait for rx high before re-arming start detection
module uart_fifo_core
   import uart_fifo_core_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] din,
   output logic              wr_rdy,
   input  logic              rd_en,
   output logic [DATA_W-1:0] dout,
   output logic              rd_rdy,
   output logic              tx_busy,
   input  logic              err_clr,
   output logic              par_err,
   output logic              frm_err,
   output logic              ovr_err,
   input  logic              rx,
   output logic              tx
);

   localparam int CW = $clog2(CLKS_PER_BIT * STOP_BITS) + 1;
   localparam int IW = $clog2(DATA_W) + 1;
   localparam bit HAS_PAR = (PARITY != PAR_NONE);

   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT * STOP_BITS - 1);
   localparam logic [IW-1:0] IDX_ONE   = IW'(1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);

   // ---------------- TX ----------------
   tx_state_t         tx_state, tx_state_n;
   logic [CW-1:0]     tx_cnt, tx_cnt_n;
   logic [IW-1:0]     tx_idx, tx_idx_n;
   logic [DATA_W-1:0] tx_sh, tx_sh_n;
   logic              tx_par, tx_par_n;
   logic              tx_load;
   logic              tx_bit;
   logic              tx_q;
   logic              tx_tc;
   logic [DATA_W-1:0] tx_head;
   logic              tx_full, tx_empty;

   uart_fifo_core_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_en   (wr_en),
      .push_data (din),
      .pop_en    (tx_load),
      .head      (tx_head),
      .full      (tx_full),
      .empty     (tx_empty)
   );

   assign wr_rdy  = !tx_full;
   assign tx_busy = (tx_state != TX_IDLE) || !tx_empty;
   assign tx_tc   = (tx_cnt == '0);

   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_idx_n   = tx_idx;
      tx_sh_n    = tx_sh;
      tx_par_n   = tx_par;
      tx_load    = 1'b0;
      case (tx_state)
         TX_IDLE: tx_load = !tx_empty;
         TX_START: begin
            if (tx_tc) begin
               tx_state_n = TX_DATA;
               tx_cnt_n   = BIT_LAST;
               tx_idx_n   = '0;
            end else tx_cnt_n = tx_cnt - CNT_ONE;
         end
         TX_DATA: begin
            if (tx_tc) begin
               tx_sh_n  = tx_sh >> 1;
               tx_cnt_n = BIT_LAST;
               tx_idx_n = tx_idx + IDX_ONE;
               if (tx_idx == IDX_LAST) begin
                  tx_state_n = HAS_PAR ? TX_PARITY : TX_STOP;
                  tx_cnt_n   = HAS_PAR ? BIT_LAST : STOP_LAST;
               end
            end else tx_cnt_n = tx_cnt - CNT_ONE;
         end
         TX_PARITY: begin
            if (tx_tc) begin
               tx_state_n = TX_STOP;
               tx_cnt_n   = STOP_LAST;
            end else tx_cnt_n = tx_cnt - CNT_ONE;
         end
         TX_STOP: begin
            if (tx_tc) begin
               tx_state_n = TX_IDLE;
               tx_load    = !tx_empty;
            end else tx_cnt_n = tx_cnt - CNT_ONE;
         end
         default: tx_state_n = TX_IDLE;
      endcase
      // Loading from IDLE or straight out of STOP gives back-to-back frames.
      if (tx_load) begin
         tx_state_n = TX_START;
         tx_cnt_n   = BIT_LAST;
         tx_sh_n    = tx_head;
         tx_par_n   = par_calc(^tx_head, PARITY);
      end
   end

   always_comb begin
      case (tx_state)
         TX_START:  tx_bit = 1'b0;
         TX_DATA:   tx_bit = tx_sh[0];
         TX_PARITY: tx_bit = tx_par;
         default:   tx_bit = 1'b1;
      endcase
   end

   // tx is registered so the pin is glitch-free; it trails the state by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_sh    <= '0;
         tx_par   <= 1'b0;
         tx_q     <= 1'b1;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_idx   <= tx_idx_n;
         tx_sh    <= tx_sh_n;
         tx_par   <= tx_par_n;
         tx_q     <= tx_bit;
      end
   end

   assign tx = tx_q;

   // ---------------- RX ----------------
   rx_state_t         rx_state, rx_state_n;
   logic [CW-1:0]     rx_cnt, rx_cnt_n;
   logic [IW-1:0]     rx_idx, rx_idx_n;
   logic [DATA_W-1:0] rx_sh, rx_sh_n;
   logic              rx_s1, rx_s2;
   logic              rx_tc;
   logic              rx_push;
   logic              par_set, frm_set, ovr_set;
   logic              rx_full, rx_empty;

   uart_fifo_core_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_en   (rx_push),
      .push_data (rx_sh),
      .pop_en    (rd_en),
      .head      (dout),
      .full      (rx_full),
      .empty     (rx_empty)
   );

   assign rd_rdy = !rx_empty;
   assign rx_tc  = (rx_cnt == '0);
   // A full FIFO still accepts the word if the host pops in the same cycle.
   assign ovr_set = rx_push && rx_full && !rd_en;

   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt;
      rx_idx_n   = rx_idx;
      rx_sh_n    = rx_sh;
      rx_push    = 1'b0;
      par_set    = 1'b0;
      frm_set    = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (!rx_s2) begin
               rx_state_n = RX_START;
               rx_cnt_n   = HALF_LAST;
            end
         end
         RX_START: begin
            if (rx_tc) begin
               if (rx_s2) rx_state_n = RX_IDLE;
               else begin
                  rx_state_n = RX_DATA;
                  rx_cnt_n   = BIT_LAST;
                  rx_idx_n   = '0;
               end
            end else rx_cnt_n = rx_cnt - CNT_ONE;
         end
         RX_DATA: begin
            if (rx_tc) begin
               rx_sh_n  = {rx_s2, rx_sh[DATA_W-1:1]};
               rx_cnt_n = BIT_LAST;
               rx_idx_n = rx_idx + IDX_ONE;
               if (rx_idx == IDX_LAST) rx_state_n = HAS_PAR ? RX_PARITY : RX_STOP;
            end else rx_cnt_n = rx_cnt - CNT_ONE;
         end
         RX_PARITY: begin
            if (rx_tc) begin
               par_set    = (rx_s2 != par_calc(^rx_sh, PARITY));
               rx_state_n = RX_STOP;
               rx_cnt_n   = BIT_LAST;
            end else rx_cnt_n = rx_cnt - CNT_ONE;
         end
         RX_STOP: begin
            if (rx_tc) begin
               rx_push    = 1'b1;
               frm_set    = !rx_s2;
               rx_state_n = RX_WAIT;
            end else rx_cnt_n = rx_cnt - CNT_ONE;
         end
         RX_WAIT: if (rx_s2) rx_state_n = RX_IDLE;
         default: rx_state_n = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_idx   <= '0;
         rx_sh    <= '0;
         par_err  <= 1'b0;
         frm_err  <= 1'b0;
         ovr_err  <= 1'b0;
      end else begin
         rx_s1    <= rx;
         rx_s2    <= rx_s1;
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_idx   <= rx_idx_n;
         rx_sh    <= rx_sh_n;
         par_err  <= (par_err && !err_clr) || par_set;
         frm_err  <= (frm_err && !err_clr) || frm_set;
         ovr_err  <= (ovr_err && !err_clr) || ovr_set;
      end
   end

endmodule
